toggle_scheduler: RTL and testbench

Round-robin scheduler that shares a single tick slot among `NCH` toggle-register channels.
- Collects per-channel toggle requests and queues one pending request per channel.
- Issues at most one single-cycle `tg_tick` strobe at a time, separated by a programmable guard gap.
- Sits between the debounced user inputs (buttons, timers) and a bank of toggle data registers, each driven by one `tg_tick` bit.

---
 rtl/toggle_sched_pkg.sv | 13 +
 rtl/toggle_scheduler_rr_pick.sv | 33 +++
 rtl/toggle_scheduler.sv | 139 +++++++++++++
 tb/tb_toggle_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_sched_pkg.sv
// Shared definitions for toggle_scheduler: FSM state encoding and index-width helper.
package toggle_sched_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    // Width of a channel index; never below one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/toggle_scheduler_rr_pick.sv
// Combinational round-robin first-set search over the pending vector, starting at ptr.
module rr_pick
    import toggle_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = id_w(NCH)
) (
    input  logic [NCH-1:0] pending,
    input  logic [IW-1:0]  ptr,
    output logic [IW-1:0]  sel,
    output logic           any
);

    always_comb begin
        int idx;
        logic [IW-1:0] idx_v;
        sel   = '0;
        any   = 1'b0;
        idx   = 0;
        idx_v = '0;
        // Walk farthest-first so the nearest set bit from ptr is the last one written.
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) idx = idx - NCH;
            idx_v = IW'(idx);
            if (pending[idx_v]) begin
                sel = idx_v;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/toggle_scheduler.sv
// Round-robin tick scheduler for NCH toggle channels with a guard gap between ticks.
// Optional periodic auto-toggle enabled by defining TOGGLE_SCHEDULER_AUTO_TOGGLE_EN.
module toggle_scheduler
    import toggle_sched_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int GAP         = 2,
    parameter int AUTO_PERIOD = 50_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          req,
    input  logic [NCH-1:0]          en,
`ifdef TOGGLE_SCHEDULER_AUTO_TOGGLE_EN
    input  logic [NCH-1:0]          auto_mask,
`endif
    input  logic                    clr_ovf,
    output logic [NCH-1:0]          tg_tick,
    output logic [$clog2(NCH)-1:0]  grant_id,
    output logic                    busy,
    output logic [NCH-1:0]          pending,
    output logic [NCH-1:0]          ovf
);

    localparam int IW = id_w(NCH);

    logic [1:0]     state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  grant_q, grant_d;
    logic [7:0]     gap_q, gap_d;
    logic [NCH-1:0] req_in, req_q;
    logic [NCH-1:0] pending_q, pending_d;
    logic [NCH-1:0] ovf_q, ovf_d;
    logic [NCH-1:0] tick_q, tick_d;
    logic [NCH-1:0] grant_vec;
    logic [IW-1:0]  pick_sel;
    logic           pick_any;

    // The prescaler only exists in the auto-toggle build; a degenerate period is left unbuilt.
    if (AUTO_PERIOD < 2) begin : g_auto_period_invalid
    end

`ifdef TOGGLE_SCHEDULER_AUTO_TOGGLE_EN
    logic [31:0] pre_q;
    logic        pre_wrap;

    assign pre_wrap = (pre_q == 32'(AUTO_PERIOD - 1));
    assign req_in   = req | (pre_wrap ? (auto_mask & en) : '0);

    always_ff @(posedge clk) begin
        if (rst)           pre_q <= '0;
        else if (pre_wrap) pre_q <= '0;
        else               pre_q <= pre_q + 32'd1;
    end
`else
    assign req_in = req;
`endif

    rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
        .pending (pending_q),
        .ptr     (ptr_q),
        .sel     (pick_sel),
        .any     (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        gap_d     = gap_q;
        tick_d    = '0;
        grant_vec = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    state_d          = S_ISSUE;
                    grant_d          = pick_sel;
                    tick_d[pick_sel] = 1'b1;
                end
            end
            S_ISSUE: begin
                grant_vec[grant_q] = 1'b1;
                ptr_d   = (grant_q == IW'(NCH - 1)) ? '0 : grant_q + IW'(1);
                gap_d   = '0;
                state_d = (GAP == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (gap_q == 8'(GAP - 1)) state_d = S_IDLE;
                else                      gap_d   = gap_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A request always leaves the channel pending; it only overflows if nothing is draining it.
    always_comb begin
        pending_d = pending_q;
        ovf_d     = clr_ovf ? '0 : ovf_q;
        for (int i = 0; i < NCH; i++) begin
            if (!en[i]) begin
                pending_d[i] = 1'b0;
            end else if (req_q[i]) begin
                if (pending_q[i] && !grant_vec[i]) ovf_d[i] = 1'b1;
                pending_d[i] = 1'b1;
            end else if (grant_vec[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            gap_q     <= '0;
            req_q     <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
            tick_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            gap_q     <= gap_d;
            req_q     <= req_in;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            tick_q    <= tick_d;
        end
    end

    assign tg_tick  = tick_q;
    assign grant_id = grant_q;
    assign busy     = (state_q == S_ISSUE) || (state_q == S_GAP);
    assign pending  = pending_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_toggle_scheduler.sv
// Self-checking bench for toggle_scheduler: slot-occupancy model plus directed literal checks.
module tb_toggle_scheduler;

    localparam int NCH         = 4;
    localparam int GAP         = 2;
    localparam int AUTO_PERIOD = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] req = '0;
    logic [NCH-1:0] en  = '1;
    logic           clr_ovf = 1'b0;
    logic [NCH-1:0] auto_mask = '0;
    logic [NCH-1:0] tg_tick;
    logic [1:0]     grant_id;
    logic           busy;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit started = 0;
    int tq_ch[$];
    int tq_cyc[$];

    always #5 clk = ~clk;

    toggle_scheduler #(.NCH(NCH), .GAP(GAP), .AUTO_PERIOD(AUTO_PERIOD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .en        (en),
`ifdef TOGGLE_SCHEDULER_AUTO_TOGGLE_EN
        .auto_mask (auto_mask),
`endif
        .clr_ovf   (clr_ovf),
        .tg_tick   (tg_tick),
        .grant_id  (grant_id),
        .busy      (busy),
        .pending   (pending),
        .ovf       (ovf)
    );

    // Model: the slot is either free or occupied for GAP+1 more cycles after a tick.
    logic [NCH-1:0] m_req = '0, m_pend = '0, m_ovf = '0, m_tick = '0;
    int m_gid = 0, m_ptr = 0, m_left = 0, m_pre = 0;

    always @(posedge clk) begin : model
        logic [NCH-1:0] rin, np, no;
        bit issuing, found;
        int c;
        cyc <= cyc + 1;
        rin = req;
`ifdef TOGGLE_SCHEDULER_AUTO_TOGGLE_EN
        if (m_pre == AUTO_PERIOD - 1) rin = rin | (auto_mask & en);
`endif
        if (rst) begin
            m_req <= '0; m_pend <= '0; m_ovf <= '0; m_tick <= '0;
            m_gid <= 0; m_ptr <= 0; m_left <= 0; m_pre <= 0;
            started <= 1'b1;
        end else begin
            issuing = (m_tick != '0);
            np = m_pend;
            no = clr_ovf ? '0 : m_ovf;
            for (int i = 0; i < NCH; i++) begin
                if (!en[i]) np[i] = 1'b0;
                else if (m_req[i]) begin
                    if (m_pend[i] && !(issuing && m_gid == i)) no[i] = 1'b1;
                    np[i] = 1'b1;
                end else if (issuing && m_gid == i) np[i] = 1'b0;
            end
            m_tick <= '0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (issuing) m_ptr <= (m_gid + 1) % NCH;
            end else begin
                found = 0;
                for (int k = 0; k < NCH; k++) begin
                    c = (m_ptr + k) % NCH;
                    if (!found && m_pend[c]) begin
                        found = 1;
                        m_tick <= NCH'(1) << c;
                        m_gid  <= c;
                        m_left <= GAP + 1;
                    end
                end
            end
            m_req  <= rin;
            m_pend <= np;
            m_ovf  <= no;
            m_pre  <= (m_pre == AUTO_PERIOD - 1) ? 0 : m_pre + 1;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp("model_tg_tick",  int'(tg_tick),  int'(m_tick));
            cmp("model_grant_id", int'(grant_id), m_gid);
            cmp("model_busy",     int'(busy),     int'(m_left > 0));
            cmp("model_pending",  int'(pending),  int'(m_pend));
            cmp("model_ovf",      int'(ovf),      int'(m_ovf));
        end
        if (tg_tick != '0) begin
            for (int i = 0; i < NCH; i++)
                if (tg_tick[i]) begin
                    tq_ch.push_back(i);
                    tq_cyc.push_back(cyc);
                end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        tq_ch.delete();
        tq_cyc.delete();
    endtask

    initial begin
        // Reset state and single-request latency.
        step(2);
        cmp("rst_tg_tick", int'(tg_tick), 0);
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_pending", int'(pending), 0);
        cmp("rst_ovf", int'(ovf), 0);
        cmp("rst_grant_id", int'(grant_id), 0);
        rst = 1'b0;
        req = 4'b0001;
        step(1);
        req = 4'b0000;
        cmp("lat_pending_k", int'(pending), 0);
        step(1);
        cmp("lat_pending_k1", int'(pending), 1);
        step(1);
        cmp("lat_tick", int'(tg_tick), 1);
        cmp("lat_grant", int'(grant_id), 0);
        cmp("lat_busy1", int'(busy), 1);
        step(1);
        cmp("lat_tick_off", int'(tg_tick), 0);
        cmp("lat_busy2", int'(busy), 1);
        step(1);
        cmp("lat_busy3", int'(busy), 1);
        step(1);
        cmp("lat_busy_end", int'(busy), 0);

        // All four channels at once.
        do_reset();
        req = 4'b1111;
        step(1);
        req = 4'b0000;
        step(20);
        cmp("all_count", tq_ch.size(), 4);
        if (tq_ch.size() == 4) begin
            for (int i = 0; i < 4; i++) cmp("all_order", tq_ch[i], i);
            for (int i = 0; i < 3; i++) cmp("all_spacing", tq_cyc[i+1] - tq_cyc[i], 4);
        end
        cmp("all_pending_drained", int'(pending), 0);

        // Overflow on channel 2 and clear.
        do_reset();
        req = 4'b0100;
        step(2);
        req = 4'b0000;
        step(10);
        cmp("ovf_set", int'(ovf), 4);
        cmp("ovf_tick_count", tq_ch.size(), 1);
        if (tq_ch.size() == 1) cmp("ovf_tick_ch", tq_ch[0], 2);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        cmp("ovf_cleared", int'(ovf), 0);

        // Pointer wrap: channel 2 ticks, then 3 and 0 arrive during its gap.
        do_reset();
        req = 4'b0100;
        step(1);
        req = 4'b0000;
        step(2);
        req = 4'b1001;
        step(1);
        req = 4'b0000;
        step(1);
        cmp("wrap_pending", int'(pending), 9);
        step(12);
        cmp("wrap_count", tq_ch.size(), 3);
        if (tq_ch.size() == 3) begin
            cmp("wrap_first", tq_ch[0], 2);
            cmp("wrap_second", tq_ch[1], 3);
            cmp("wrap_third", tq_ch[2], 0);
        end

        // Disabled channel ignores its request; reset during the gap.
        do_reset();
        en = 4'b1101;
        req = 4'b0010;
        step(1);
        req = 4'b0000;
        step(6);
        cmp("dis_pending", int'(pending), 0);
        cmp("dis_no_tick", tq_ch.size(), 0);
        en = 4'b1111;
        req = 4'b0001;
        step(1);
        req = 4'b0000;
        step(3);
        cmp("gap_busy", int'(busy), 1);
        rst = 1'b1;
        step(1);
        cmp("midrst_tick", int'(tg_tick), 0);
        cmp("midrst_busy", int'(busy), 0);
        cmp("midrst_grant", int'(grant_id), 0);
        cmp("midrst_pending", int'(pending), 0);
        cmp("midrst_ovf", int'(ovf), 0);
        rst = 1'b0;

`ifdef TOGGLE_SCHEDULER_AUTO_TOGGLE_EN
        // Periodic auto-toggle on channel 2.
        do_reset();
        auto_mask = 4'b0100;
        step(45);
        auto_mask = 4'b0000;
        cmp("auto_enough_ticks", int'(tq_ch.size() >= 3), 1);
        for (int i = 0; i < tq_ch.size(); i++) cmp("auto_ch", tq_ch[i], 2);
        for (int i = 0; i + 1 < tq_ch.size(); i++)
            cmp("auto_period", tq_cyc[i+1] - tq_cyc[i], AUTO_PERIOD);
`endif

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
